// File: rtl/hweval_lane_shell_if.sv
// Pad-side and core-side signal bundle for hweval_lane_shell.
// The shell takes the slave modport; the pads/core environment takes the master modport.
interface hweval_lane_shell_if #(
  parameter int LANES    = 257,
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 8,
  parameter int MODIDX_W = 6
);
  logic                       start_in;
  logic [MODIDX_W-1:0]        mod_idx_in;
  logic                       mem_read_in;
  logic                       mem_write_in;
  logic                       shift_en_in;
  logic [ADDR_W-1:0]          mem_addr_in;
  logic [DATA_W-1:0]          din_in;
  logic [DATA_W-1:0]          dout_out;
  logic                       dout_valid_out;
  logic                       done_out;
  logic                       busy_out;
  logic                       core_start;
  logic [MODIDX_W-1:0]        core_mod_idx;
  logic                       core_mem_read;
  logic                       core_mem_write;
  logic [ADDR_W*LANES-1:0]    core_mem_addr;
  logic [DATA_W*LANES-1:0]    core_din;
  logic [DATA_W*LANES-1:0]    core_dout;
  logic                       core_done;

  modport slave (
    input  start_in, mod_idx_in, mem_read_in, mem_write_in, shift_en_in,
           mem_addr_in, din_in, core_dout, core_done,
    output dout_out, dout_valid_out, done_out, busy_out, core_start,
           core_mod_idx, core_mem_read, core_mem_write, core_mem_addr, core_din
  );

  modport master (
    output start_in, mod_idx_in, mem_read_in, mem_write_in, shift_en_in,
           mem_addr_in, din_in, core_dout, core_done,
    input  dout_out, dout_valid_out, done_out, busy_out, core_start,
           core_mod_idx, core_mem_read, core_mem_write, core_mem_addr, core_din
  );
endinterface

// File: rtl/hweval_lane_shell.sv
// Pin-limited shell: deserialises pad words into wide core lanes and serialises the core result back.
// Optional feature macro HWEVAL_CHECKSUM_EN adds an XOR checksum of the unloaded words on checksum_out.
module hweval_lane_shell #(
  parameter int LANES    = 257,
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 8,
  parameter int MODIDX_W = 6
) (
  input  logic                  clk,
  input  logic                  reset,
`ifdef HWEVAL_CHECKSUM_EN
  hweval_lane_shell_if.slave    bus,
  output logic [DATA_W-1:0]     checksum_out
`else
  hweval_lane_shell_if.slave    bus
`endif
);

  localparam int CNT_W = $clog2(LANES + 1);
  localparam logic [CNT_W-1:0] LANES_C = CNT_W'(LANES);
  localparam logic [CNT_W-1:0] LAST_C  = CNT_W'(LANES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    UNLOAD = 2'd2
  } state_t;

  state_t                    state_q, state_d;
  logic [DATA_W*LANES-1:0]   unload_q, unload_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic                      start_q, start_d;
  logic                      done_q;
  logic                      capture;
  logic                      dout_valid;
  logic [MODIDX_W-1:0]       mod_idx_q;
  logic                      mem_read_q;
  logic                      mem_write_q;
  logic [ADDR_W*LANES-1:0]   addr_chain_q;
  logic [DATA_W*LANES-1:0]   din_chain_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mod_idx_q    <= '0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      addr_chain_q <= '0;
      din_chain_q  <= '0;
    end else begin
      mod_idx_q   <= bus.mod_idx_in;
      mem_read_q  <= bus.mem_read_in;
      mem_write_q <= bus.mem_write_in;
      // Newest pad word always lands in lane 0; older words move up one lane.
      if (bus.shift_en_in) begin
        addr_chain_q <= {addr_chain_q[ADDR_W*(LANES-1)-1:0], bus.mem_addr_in};
        din_chain_q  <= {din_chain_q[DATA_W*(LANES-1)-1:0], bus.din_in};
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      unload_q <= '0;
      cnt_q    <= '0;
      start_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      unload_q <= unload_d;
      cnt_q    <= cnt_d;
      start_q  <= start_d;
      done_q   <= capture;
    end
  end

  // A start request in IDLE outranks a simultaneous core_done; otherwise core_done always recaptures.
  assign capture = bus.core_done && !((state_q == IDLE) && bus.start_in);

  always_comb begin
    state_d  = state_q;
    unload_d = unload_q;
    cnt_d    = cnt_q;
    start_d  = 1'b0;
    if (capture) begin
      unload_d = bus.core_dout;
      cnt_d    = '0;
      state_d  = UNLOAD;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.start_in) begin
            start_d = 1'b1;
            state_d = RUN;
          end
        end
        RUN: begin
          state_d = RUN;
        end
        UNLOAD: begin
          unload_d = unload_q >> DATA_W;
          if (cnt_q < LANES_C) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
          if (cnt_q >= LAST_C) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign dout_valid = (state_q == UNLOAD) && (cnt_q < LANES_C);

  assign bus.dout_out       = dout_valid ? unload_q[DATA_W-1:0] : '0;
  assign bus.dout_valid_out = dout_valid;
  assign bus.done_out       = done_q;
  assign bus.busy_out       = (state_q != IDLE);
  assign bus.core_start     = start_q;
  assign bus.core_mod_idx   = mod_idx_q;
  assign bus.core_mem_read  = mem_read_q;
  assign bus.core_mem_write = mem_write_q;
  assign bus.core_mem_addr  = addr_chain_q;
  assign bus.core_din       = din_chain_q;

`ifdef HWEVAL_CHECKSUM_EN
  logic [DATA_W-1:0] csum_q;

  // Clearing on capture wins over accumulating, so a restarted unload sums only the new words.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      csum_q <= '0;
    end else if (capture) begin
      csum_q <= '0;
    end else if (dout_valid) begin
      csum_q <= csum_q ^ bus.dout_out;
    end
  end

  assign checksum_out = csum_q;
`endif

endmodule

// File: tb/tb_hweval_lane_shell.sv
// Directed self-checking bench for hweval_lane_shell with LANES=4.
// Define HWEVAL_CHECKSUM_EN to also exercise the checksum port.
module tb_hweval_lane_shell;

  localparam int LANES    = 4;
  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 8;
  localparam int MODIDX_W = 6;

  logic clk;
  logic reset;
  int   checkCount;
  int   errorCount;

  hweval_lane_shell_if #(
    .LANES(LANES), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .MODIDX_W(MODIDX_W)
  ) bus ();

`ifdef HWEVAL_CHECKSUM_EN
  logic [DATA_W-1:0] checksum;
`endif

  hweval_lane_shell #(
    .LANES(LANES), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .MODIDX_W(MODIDX_W)
  ) dut (
    .clk(clk),
    .reset(reset),
`ifdef HWEVAL_CHECKSUM_EN
    .bus(bus),
    .checksum_out(checksum)
`else
    .bus(bus)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n clock edges and settle 1ns after the last one.
  task automatic applyStimulus(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  // Present {lane3,lane2,lane1,lane0} on core_dout and pulse core_done for one edge.
  task automatic pulseDone(input logic [127:0] lanes);
    bus.core_dout = lanes;
    bus.core_done = 1'b1;
    applyStimulus(1);
    bus.core_done = 1'b0;
  endtask

  logic [31:0] words[4];
  logic [31:0] expWords[4];

  initial begin
    checkCount = 0;
    errorCount = 0;
    reset              = 1'b1;
    bus.start_in       = 1'b0;
    bus.mod_idx_in     = '0;
    bus.mem_read_in    = 1'b0;
    bus.mem_write_in   = 1'b0;
    bus.shift_en_in    = 1'b0;
    bus.mem_addr_in    = '0;
    bus.din_in         = '0;
    bus.core_dout      = '0;
    bus.core_done      = 1'b0;
    applyStimulus(2);
    checkOutput("rst_busy", 128'(bus.busy_out), 128'd0);
    checkOutput("rst_valid", 128'(bus.dout_valid_out), 128'd0);
    checkOutput("rst_dout", 128'(bus.dout_out), 128'd0);
    checkOutput("rst_core_start", 128'(bus.core_start), 128'd0);
    checkOutput("rst_done", 128'(bus.done_out), 128'd0);
    reset = 1'b0;
    applyStimulus(1);

    // Input registers: one cycle latency.
    bus.mod_idx_in   = 6'h2A;
    bus.mem_read_in  = 1'b1;
    bus.mem_write_in = 1'b0;
    applyStimulus(1);
    checkOutput("mod_idx", 128'(bus.core_mod_idx), 128'h2A);
    checkOutput("mem_read", 128'(bus.core_mem_read), 128'd1);
    bus.mem_read_in  = 1'b0;
    bus.mem_write_in = 1'b1;
    applyStimulus(1);
    checkOutput("mem_write", 128'(bus.core_mem_write), 128'd1);
    checkOutput("mem_read_low", 128'(bus.core_mem_read), 128'd0);

    // Lane chains.
    words[0] = 32'h11; words[1] = 32'h22; words[2] = 32'h33; words[3] = 32'h44;
    bus.shift_en_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.din_in      = words[i];
      bus.mem_addr_in = words[i][7:0];
      applyStimulus(1);
      checkOutput($sformatf("chain_lane0_%0d", i), 128'(bus.core_din[31:0]), 128'(words[i]));
    end
    checkOutput("chain_din", 128'(bus.core_din), 128'h00000011_00000022_00000033_00000044);
    checkOutput("chain_addr", 128'(bus.core_mem_addr), 128'h11223344);
    bus.shift_en_in = 1'b0;
    bus.din_in      = 32'h55;
    bus.mem_addr_in = 8'h55;
    applyStimulus(2);
    checkOutput("chain_hold", 128'(bus.core_din), 128'h00000011_00000022_00000033_00000044);

    // Start and ignored second start in RUN.
    bus.start_in = 1'b1;
    applyStimulus(1);
    bus.start_in = 1'b0;
    checkOutput("core_start_pulse", 128'(bus.core_start), 128'd1);
    checkOutput("busy_run", 128'(bus.busy_out), 128'd1);
    applyStimulus(1);
    checkOutput("core_start_low", 128'(bus.core_start), 128'd0);
    bus.start_in = 1'b1;
    applyStimulus(1);
    bus.start_in = 1'b0;
    checkOutput("start_in_run", 128'(bus.core_start), 128'd0);
    checkOutput("busy_still", 128'(bus.busy_out), 128'd1);

    // Core completion and full unload.
    expWords[0] = 32'hA0A0_0001; expWords[1] = 32'hB0B0_0002;
    expWords[2] = 32'hC0C0_0003; expWords[3] = 32'hD0D0_0004;
    pulseDone(128'hD0D00004_C0C00003_B0B00002_A0A00001);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("unload_valid_%0d", i), 128'(bus.dout_valid_out), 128'd1);
      checkOutput($sformatf("unload_dout_%0d", i), 128'(bus.dout_out), 128'(expWords[i]));
      checkOutput($sformatf("unload_done_%0d", i), 128'(bus.done_out), (i == 0) ? 128'd1 : 128'd0);
      applyStimulus(1);
    end
    checkOutput("after_valid", 128'(bus.dout_valid_out), 128'd0);
    checkOutput("after_dout", 128'(bus.dout_out), 128'd0);
    checkOutput("after_busy", 128'(bus.busy_out), 128'd0);

    // Recapture at the second valid cycle.
    bus.start_in = 1'b1;
    applyStimulus(1);
    bus.start_in = 1'b0;
    applyStimulus(1);
    pulseDone(128'hD0D00004_C0C00003_B0B00002_A0A00001);
    checkOutput("re_first", 128'(bus.dout_out), 128'hA0A00001);
    applyStimulus(1);
    checkOutput("re_second", 128'(bus.dout_out), 128'hB0B00002);
    expWords[0] = 32'hE0E0_0005; expWords[1] = 32'hF0F0_0006;
    expWords[2] = 32'h1234_5678; expWords[3] = 32'h9ABC_DEF0;
    pulseDone(128'h9ABCDEF0_12345678_F0F00006_E0E00005);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("re_valid_%0d", i), 128'(bus.dout_valid_out), 128'd1);
      checkOutput($sformatf("re_dout_%0d", i), 128'(bus.dout_out), 128'(expWords[i]));
      applyStimulus(1);
    end
    checkOutput("re_after_valid", 128'(bus.dout_valid_out), 128'd0);
    checkOutput("re_after_busy", 128'(bus.busy_out), 128'd0);

    // Reset in the middle of an unload taken from IDLE.
    pulseDone(128'h00000008_00000004_00000002_00000001);
    applyStimulus(1);
    checkOutput("pre_reset_valid", 128'(bus.dout_valid_out), 128'd1);
    reset = 1'b1;
    #1;
    checkOutput("mid_reset_valid", 128'(bus.dout_valid_out), 128'd0);
    checkOutput("mid_reset_busy", 128'(bus.busy_out), 128'd0);
    checkOutput("mid_reset_dout", 128'(bus.dout_out), 128'd0);
    checkOutput("mid_reset_chain", 128'(bus.core_din), 128'd0);
    applyStimulus(1);
    reset = 1'b0;
    applyStimulus(2);
    checkOutput("post_reset_busy", 128'(bus.busy_out), 128'd0);
    checkOutput("post_reset_valid", 128'(bus.dout_valid_out), 128'd0);

`ifdef HWEVAL_CHECKSUM_EN
    bus.core_dout = 128'h00000008_00000004_00000002_00000001;
    bus.core_done = 1'b1;
    applyStimulus(1);
    bus.core_done = 1'b0;
    checkOutput("csum_clear", 128'(checksum), 128'd0);
    applyStimulus(4);
    checkOutput("csum_final", 128'(checksum), 128'hF);
    applyStimulus(2);
    checkOutput("csum_hold", 128'(checksum), 128'hF);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
